// File: rtl/timer_multi_pkg.sv
// ---------------------------------------------------------------------------
// timer_multi_pkg
//   Shared definitions for the multi-channel bus timer: register offsets,
//   CTRL bit positions, channel stride, the CTRL struct and small helpers
//   for packing/unpacking CTRL and computing channel register offsets.
// ---------------------------------------------------------------------------
package timer_multi_pkg;

    // Per-channel register offsets within a channel's 16-byte window
    localparam logic [3:0] OFF_CTRL    = 4'h0;
    localparam logic [3:0] OFF_COUNT   = 4'h4;
    localparam logic [3:0] OFF_COMPARE = 4'h8;

    // Global registers
    localparam logic [8:0] ADDR_STATUS   = 9'h100;
    localparam logic [8:0] ADDR_PRESCALE = 9'h104;

    // Byte distance between consecutive channel windows
    localparam int CH_STRIDE = 16;

    // CTRL bit indices
    localparam int CTRL_EN       = 0;
    localparam int CTRL_PERIODIC = 1;
    localparam int CTRL_IRQ_EN   = 2;

    // Packed so that en lands in bit 0, matching the register layout
    typedef struct packed {
        logic irq_en;
        logic periodic;
        logic en;
    } ctrl_t;

    function automatic ctrl_t ctrl_from_bits(logic [2:0] bits);
        ctrl_t c;
        c.en       = bits[CTRL_EN];
        c.periodic = bits[CTRL_PERIODIC];
        c.irq_en   = bits[CTRL_IRQ_EN];
        return c;
    endfunction

    function automatic logic [31:0] ctrl_to_word(ctrl_t c);
        return {29'b0, c};
    endfunction

    // Low address byte of register reg_off in channel ch
    function automatic logic [7:0] ch_offset(int ch, logic [3:0] reg_off);
        return 8'(ch * CH_STRIDE) + {4'b0, reg_off};
    endfunction

endpackage

// File: rtl/timer_multi_ch.sv
// ---------------------------------------------------------------------------
// timer_multi_ch
//   One timer channel: CTRL, COUNT, COMPARE and the sticky pending flop.
//   Ports:
//     clk, reset_n           clock, async active-low reset
//     tick                   advance strobe shared by all channels
//     ctrl_we/count_we/
//     compare_we             decoded bus write strobes for this channel
//     wdata                  bus write data
//     clr                    write-1-to-clear request for pending
//     ctrl/count/compare     register values for readback
//     pending, irq           pending flag and pending & irq_en
// ---------------------------------------------------------------------------
module timer_multi_ch
    import timer_multi_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tick,
    input  logic             ctrl_we,
    input  logic             count_we,
    input  logic             compare_we,
    input  logic [31:0]      wdata,
    input  logic             clr,
    output ctrl_t            ctrl,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] compare,
    output logic             pending,
    output logic             irq
);

    logic step;
    logic match;

    assign step  = tick & ctrl.en;
    assign match = step & (count == compare);
    assign irq   = pending & ctrl.irq_en;

    // Bus writes to CTRL or COUNT take priority over the tick update of
    // count/en; pending is set by a match regardless and beats a W1C clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl    <= '0;
            count   <= '0;
            compare <= '1;
            pending <= 1'b0;
        end else begin
            if (ctrl_we) begin
                ctrl <= ctrl_from_bits(wdata[2:0]);
            end else if (match && !ctrl.periodic && !count_we) begin
                ctrl.en <= 1'b0;
            end

            if (count_we) begin
                count <= wdata[WIDTH-1:0];
            end else if (step && !ctrl_we) begin
                if (!match) begin
                    count <= count + 1'b1;
                end else if (ctrl.periodic) begin
                    count <= '0;
                end
            end

            if (compare_we) begin
                compare <= wdata[WIDTH-1:0];
            end

            if (match) begin
                pending <= 1'b1;
            end else if (clr) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/timer_multi.sv
// ---------------------------------------------------------------------------
// timer_multi
//   Multi-channel bus timer. N_CH channels of WIDTH-bit counters with
//   compare, one-shot/periodic modes, sticky W1C pending bits and one
//   OR-reduced interrupt line.
//   Optional feature macro: TIMER_MULTI_PRESCALE_EN (PS_W-bit prescaler
//   generating tick; otherwise tick is constant 1 and 0x104 reads 0).
//   Ports:
//     clk, reset_n     clock, async active-low reset
//     addr, wdata, we  simple bus write port (addr[8:0] decoded)
//     rdata            combinational read data, unmapped reads 0
//     irq_vec          per-channel pending & irq_en
//     timer_irq        OR of irq_vec
// ---------------------------------------------------------------------------
module timer_multi
    import timer_multi_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int WIDTH = 32,
    parameter int PS_W  = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [31:0]     addr,
    input  logic [31:0]     wdata,
    input  logic            we,
    output logic [31:0]     rdata,
    output logic [N_CH-1:0] irq_vec,
    output logic            timer_irq
);

    logic [8:0]       off;
    logic             tick;
    logic             status_we;
    logic [N_CH-1:0]  clr;
    logic [N_CH-1:0]  ctrl_we;
    logic [N_CH-1:0]  count_we;
    logic [N_CH-1:0]  compare_we;
    logic [N_CH-1:0]  pending;
    logic [31:0]      prescale_rd;
    ctrl_t            ch_ctrl    [N_CH];
    logic [WIDTH-1:0] ch_count   [N_CH];
    logic [WIDTH-1:0] ch_compare [N_CH];
    logic             unused_addr;

    assign off         = addr[8:0];
    assign unused_addr = ^addr[31:9];
    assign status_we   = we && (off == ADDR_STATUS);
    assign clr         = status_we ? wdata[N_CH-1:0] : '0;
    assign timer_irq   = |irq_vec;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign ctrl_we[i]    = we && !off[8] && (off[7:0] == ch_offset(i, OFF_CTRL));
        assign count_we[i]   = we && !off[8] && (off[7:0] == ch_offset(i, OFF_COUNT));
        assign compare_we[i] = we && !off[8] && (off[7:0] == ch_offset(i, OFF_COMPARE));

        timer_multi_ch #(
            .WIDTH (WIDTH)
        ) u_ch (
            .clk        (clk),
            .reset_n    (reset_n),
            .tick       (tick),
            .ctrl_we    (ctrl_we[i]),
            .count_we   (count_we[i]),
            .compare_we (compare_we[i]),
            .wdata      (wdata),
            .clr        (clr[i]),
            .ctrl       (ch_ctrl[i]),
            .count      (ch_count[i]),
            .compare    (ch_compare[i]),
            .pending    (pending[i]),
            .irq        (irq_vec[i])
        );
    end

`ifdef TIMER_MULTI_PRESCALE_EN
    logic [PS_W-1:0] prescale;
    logic [PS_W-1:0] ps_cnt;
    logic            prescale_we;

    assign prescale_we = we && (off == ADDR_PRESCALE);
    assign tick        = (ps_cnt == prescale);
    assign prescale_rd = 32'(prescale);

    // Free-running divider; rewriting PRESCALE restarts the count so the
    // new period starts cleanly from the write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescale <= '0;
            ps_cnt   <= '0;
        end else if (prescale_we) begin
            prescale <= wdata[PS_W-1:0];
            ps_cnt   <= '0;
        end else if (tick) begin
            ps_cnt <= '0;
        end else begin
            ps_cnt <= ps_cnt + 1'b1;
        end
    end
`else
    logic unused_ps;

    assign tick        = 1'b1;
    assign prescale_rd = '0;
    assign unused_ps   = (PS_W != 0);
`endif

    // Read mux: channel windows below 0x100, globals above
    always_comb begin
        rdata = '0;
        if (!off[8]) begin
            for (int i = 0; i < N_CH; i++) begin
                if (off[7:0] == ch_offset(i, OFF_CTRL)) begin
                    rdata = ctrl_to_word(ch_ctrl[i]);
                end else if (off[7:0] == ch_offset(i, OFF_COUNT)) begin
                    rdata = 32'(ch_count[i]);
                end else if (off[7:0] == ch_offset(i, OFF_COMPARE)) begin
                    rdata = 32'(ch_compare[i]);
                end
            end
        end else if (off == ADDR_STATUS) begin
            rdata = 32'(pending);
        end else if (off == ADDR_PRESCALE) begin
            rdata = prescale_rd;
        end
    end

endmodule

// File: tb/tb_timer_multi.sv
// ---------------------------------------------------------------------------
// tb_timer_multi
//   Self-checking bench for timer_multi. Directed scenarios followed by a
//   random bus phase, all compared against a behavioural register model.
// ---------------------------------------------------------------------------
module tb_timer_multi;

    localparam int N_CH = 4;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [31:0]     addr = '0;
    logic [31:0]     wdata = '0;
    logic            we = 1'b0;
    logic [31:0]     rdata;
    logic [N_CH-1:0] irq_vec;
    logic            timer_irq;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    timer_multi #(
        .N_CH  (N_CH),
        .WIDTH (32),
        .PS_W  (16)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .addr      (addr),
        .wdata     (wdata),
        .we        (we),
        .rdata     (rdata),
        .irq_vec   (irq_vec),
        .timer_irq (timer_irq)
    );

    // Behavioural model state
    logic [31:0] m_count   [N_CH];
    logic [31:0] m_compare [N_CH];
    bit          m_en      [N_CH];
    bit          m_per     [N_CH];
    bit          m_ie      [N_CH];
    bit          m_pend    [N_CH];
    int          m_prescale;
    int          m_ps_cnt;

    task automatic m_reset();
        for (int i = 0; i < N_CH; i++) begin
            m_count[i]   = 32'd0;
            m_compare[i] = 32'hFFFF_FFFF;
            m_en[i]      = 1'b0;
            m_per[i]     = 1'b0;
            m_ie[i]      = 1'b0;
            m_pend[i]    = 1'b0;
        end
        m_prescale = 0;
        m_ps_cnt   = 0;
    endtask

    function automatic logic [31:0] m_read(logic [31:0] a);
        int o;
        int ch;
        int r;
        o = int'(a[8:0]);
        if (o < 256) begin
            ch = o / 16;
            r  = o % 16;
            if (ch >= N_CH) return 32'd0;
            if (r == 0) return {29'd0, m_ie[ch], m_per[ch], m_en[ch]};
            if (r == 4) return m_count[ch];
            if (r == 8) return m_compare[ch];
            return 32'd0;
        end
        if (o == 256) begin
            logic [31:0] s;
            s = 32'd0;
            for (int i = 0; i < N_CH; i++) s[i] = m_pend[i];
            return s;
        end
`ifdef TIMER_MULTI_PRESCALE_EN
        if (o == 260) return 32'(m_prescale);
`endif
        return 32'd0;
    endfunction

    function automatic logic [N_CH-1:0] m_irq();
        logic [N_CH-1:0] v;
        for (int i = 0; i < N_CH; i++) v[i] = m_pend[i] && m_ie[i];
        return v;
    endfunction

    // One clock edge of the model given the bus inputs present at that edge
    task automatic m_step(input logic w, input logic [31:0] a, input logic [31:0] d);
        bit tick;
        bit active;
        bit hit;
        int o;
        int ch;
        int r;
        tick = 1'b1;
`ifdef TIMER_MULTI_PRESCALE_EN
        tick = (m_ps_cnt == m_prescale);
        if (w && a[8:0] == 9'h104) begin
            m_prescale = int'(d[15:0]);
            m_ps_cnt   = 0;
        end else if (tick) begin
            m_ps_cnt = 0;
        end else begin
            m_ps_cnt = m_ps_cnt + 1;
        end
`endif
        o  = int'(a[8:0]);
        ch = -1;
        r  = -1;
        if (w && o < 256) begin
            ch = o / 16;
            r  = o % 16;
        end
        for (int i = 0; i < N_CH; i++) begin
            active = tick && m_en[i];
            hit    = active && (m_count[i] == m_compare[i]);
            if (hit) m_pend[i] = 1'b1;
            else if (w && o == 256 && d[i]) m_pend[i] = 1'b0;
            if (ch == i && (r == 0 || r == 4)) begin
                if (r == 0) begin
                    m_en[i]  = d[0];
                    m_per[i] = d[1];
                    m_ie[i]  = d[2];
                end else begin
                    m_count[i] = d;
                end
            end else if (active) begin
                if (!hit) m_count[i] = m_count[i] + 32'd1;
                else if (m_per[i]) m_count[i] = 32'd0;
                else m_en[i] = 1'b0;
            end
            if (ch == i && r == 8) m_compare[i] = d;
        end
    endtask

    task automatic check32(input logic [31:0] got, input logic [31:0] exp, input string tag);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check1(input logic got, input logic exp, input string tag);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("[TB] FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // One bus cycle: drive, check outputs against the model at the negedge,
    // then advance DUT and model together on the posedge.
    task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d,
                                 input bit chk, input string tag);
        we    = w;
        addr  = a;
        wdata = d;
        @(negedge clk);
        if (chk) begin
            check32(rdata, m_read(a), {tag, " rdata"});
            check32(32'(irq_vec), 32'(m_irq()), {tag, " irq_vec"});
            check1(timer_irq, |m_irq(), {tag, " timer_irq"});
        end
        @(posedge clk);
        m_step(w, a, d);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        applyStimulus(1'b1, a, d, 1'b1, "write");
    endtask

    task automatic rd(input logic [31:0] a, input string tag);
        applyStimulus(1'b0, a, 32'd0, 1'b1, tag);
    endtask

    // Read cycle checked against a fixed expected value
    task automatic checkOutput(input logic [31:0] a, input logic [31:0] exp, input string tag);
        we    = 1'b0;
        addr  = a;
        wdata = 32'd0;
        @(negedge clk);
        check32(rdata, exp, tag);
        @(posedge clk);
        m_step(1'b0, a, 32'd0);
        #1;
    endtask

    initial begin
        bit found;
        int op;
        logic [31:0] a;
        logic [31:0] d;

        m_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        $display("[TB] reset released");

        // Reset values
        checkOutput(32'h000, 32'h0, "rst ctrl0");
        checkOutput(32'h004, 32'h0, "rst count0");
        checkOutput(32'h008, 32'hFFFF_FFFF, "rst compare0");
        checkOutput(32'h038, 32'hFFFF_FFFF, "rst compare3");
        checkOutput(32'h100, 32'h0, "rst status");
        check1(timer_irq, 1'b0, "rst timer_irq");

        // Periodic channel 0, period 5
        wr(32'h008, 32'd4);
        wr(32'h000, 32'h7);
        for (int k = 0; k < 12; k++) rd(32'h004, "periodic count0");
        rd(32'h100, "periodic status");
        check1(timer_irq, 1'b1, "periodic timer_irq");
        wr(32'h100, 32'h1);
        check1(timer_irq, 1'b0, "w1c clears irq");
        rd(32'h100, "after w1c status");

        // One-shot channel 1
        wr(32'h018, 32'd3);
        wr(32'h010, 32'h5);
        for (int k = 0; k < 7; k++) rd(32'h014, "oneshot count1");
        checkOutput(32'h010, 32'h4, "oneshot ctrl1");
        check1(irq_vec[1], 1'b1, "oneshot irq1");
        wr(32'h100, 32'h2);
        for (int k = 0; k < 6; k++) rd(32'h100, "oneshot no repend");
        checkOutput(32'h014, 32'd3, "oneshot count holds");

        // W1C in the same cycle as a channel 0 match
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (m_en[0] && m_count[0] == m_compare[0]) found = 1'b1;
            else rd(32'h004, "seek match");
        end
        check1(found, 1'b1, "match found in budget");
        applyStimulus(1'b1, 32'h100, 32'h1, 1'b1, "w1c on match");
        check1(irq_vec[0], 1'b1, "set beats w1c");
        rd(32'h100, "set beats w1c status");

        // COUNT write on a tick cycle
        wr(32'h028, 32'd100);
        wr(32'h020, 32'h1);
        wr(32'h024, 32'd10);
        checkOutput(32'h024, 32'd10, "count write on tick");
        rd(32'h024, "count after write");

        // Wrap at the top of the counter range
        wr(32'h038, 32'd1);
        wr(32'h034, 32'hFFFF_FFFE);
        wr(32'h030, 32'h5);
        checkOutput(32'h034, 32'hFFFF_FFFE, "wrap fe");
        checkOutput(32'h034, 32'hFFFF_FFFF, "wrap ff");
        checkOutput(32'h034, 32'h0, "wrap 00");
        check1(irq_vec[3], 1'b0, "no pending at wrap");
        checkOutput(32'h034, 32'h1, "wrap 01");
        check1(irq_vec[3], 1'b1, "pending after wrap match");
        wr(32'h030, 32'h0);

        // Unmapped offsets
        checkOutput(32'h00C, 32'h0, "unmapped 0x0c");
        checkOutput(32'h040, 32'h0, "unmapped ch4");
        checkOutput(32'h108, 32'h0, "unmapped 0x108");

        // Asynchronous reset mid-count, checked before any clock edge
        reset_n = 1'b0;
        we      = 1'b0;
        addr    = 32'h024;
        #1;
        check32(rdata, 32'h0, "async rst count2");
        addr = 32'h028;
        #1;
        check32(rdata, 32'hFFFF_FFFF, "async rst compare2");
        addr = 32'h100;
        #1;
        check32(rdata, 32'h0, "async rst status");
        check1(timer_irq, 1'b0, "async rst timer_irq");
        reset_n = 1'b1;
        m_reset();
        @(posedge clk);
        m_step(1'b0, addr, 32'd0);
        #1;

`ifdef TIMER_MULTI_PRESCALE_EN
        // Prescaled tick: PRESCALE=2 gives a tick every 3 cycles
        wr(32'h104, 32'd2);
        wr(32'h008, 32'd1);
        wr(32'h000, 32'h7);
        for (int k = 0; k < 14; k++) rd(32'h004, "prescale count0");
        rd(32'h100, "prescale status");
        rd(32'h104, "prescale reg");
        wr(32'h000, 32'h0);
        wr(32'h104, 32'd0);
`else
        wr(32'h104, 32'd5);
        checkOutput(32'h104, 32'h0, "prescale absent");
`endif

        // Random bus traffic
        for (int k = 0; k < 400; k++) begin
            op = int'($urandom_range(0, 9));
            a  = 32'(($urandom_range(0, N_CH - 1) * 16));
            case (op)
                0: wr(a + 32'h0, $urandom);
                1: wr(a + 32'h4, 32'($urandom_range(0, 9)));
                2: wr(a + 32'h8, 32'($urandom_range(0, 7)));
                3: wr(32'h100, $urandom);
`ifdef TIMER_MULTI_PRESCALE_EN
                4: wr(32'h104, 32'($urandom_range(0, 3)));
`else
                4: wr(32'h104, $urandom);
`endif
                5: rd(32'h100, "rand status");
                6: rd($urandom & 32'h1FF, "rand any");
                default: begin
                    d = 32'($urandom_range(0, 2) * 4);
                    rd(a + d, "rand chreg");
                end
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
